// File: rtl/cria_tiro.sv
// Shot creator: on a fire request, scans the shot table for the first free slot and
// writes a new valid shot at the ship position and direction. Reports "table full" otherwise.
module cria_tiro #(
    parameter int NUM_TIROS  = 8,
    parameter int LARG_COORD = 4,
    parameter int LARG_DIR   = 3,
    localparam int IW = $clog2(NUM_TIROS),
    localparam int W  = 1 + 2*LARG_COORD + LARG_DIR
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  iniciar,
    input  logic [LARG_COORD-1:0] nave_x,
    input  logic [LARG_COORD-1:0] nave_y,
    input  logic [LARG_DIR-1:0]   nave_dir,
    output logic [IW-1:0]         tabela_endereco,
    input  logic [W-1:0]          tabela_dado_lido,
    output logic [W-1:0]          tabela_dado_esc,
    output logic                  tabela_we,
    output logic                  ocupado,
    output logic                  criacao_concluida_tiro,
    output logic                  tabela_cheia,
    output logic [4:0]            db_estado
);

    typedef enum logic [4:0] {
        INICIAL    = 5'h00,
        ESPERA     = 5'h01,
        LE_SLOT    = 5'h02,
        AVALIA     = 5'h03,
        ESCREVE    = 5'h04,
        CONCLUIDO  = 5'h05,
        SEM_ESPACO = 5'h06
    } estado_t;

    estado_t               estado, prox_estado;
    logic [IW-1:0]         idx, idx_prox;
    logic [LARG_COORD-1:0] x_reg, y_reg;
    logic [LARG_DIR-1:0]   dir_reg;
    logic                  captura;
    logic                  slot_valido;
    logic                  unused_bits;

    // Only the valid bit of a table entry matters when looking for a free slot.
    assign slot_valido = tabela_dado_lido[W-1];
    assign unused_bits = ^tabela_dado_lido[W-2:0];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado  <= INICIAL;
            idx     <= '0;
            x_reg   <= '0;
            y_reg   <= '0;
            dir_reg <= '0;
        end else begin
            estado <= prox_estado;
            idx    <= idx_prox;
            if (captura) begin
                x_reg   <= nave_x;
                y_reg   <= nave_y;
                dir_reg <= nave_dir;
            end
        end
    end

    always_comb begin
        prox_estado            = estado;
        idx_prox               = idx;
        captura                = 1'b0;
        tabela_endereco        = idx;
        tabela_dado_esc        = '0;
        tabela_we              = 1'b0;
        ocupado                = 1'b1;
        criacao_concluida_tiro = 1'b0;
        tabela_cheia           = 1'b0;
        db_estado              = estado;

        case (estado)
            INICIAL: begin
                ocupado     = 1'b0;
                prox_estado = ESPERA;
            end
            ESPERA: begin
                ocupado = 1'b0;
                if (iniciar) begin
                    captura     = 1'b1;
                    idx_prox    = '0;
                    prox_estado = LE_SLOT;
                end
            end
            LE_SLOT: prox_estado = AVALIA;
            // Read data for idx arrives this cycle because the RAM is synchronous.
            AVALIA: begin
                if (!slot_valido) begin
                    prox_estado = ESCREVE;
                end else if (idx == IW'(NUM_TIROS - 1)) begin
                    prox_estado = SEM_ESPACO;
                end else begin
                    idx_prox    = idx + 1'b1;
                    prox_estado = LE_SLOT;
                end
            end
            ESCREVE: begin
                tabela_we       = 1'b1;
                tabela_dado_esc = {1'b1, x_reg, y_reg, dir_reg};
                prox_estado     = CONCLUIDO;
            end
            // Clearing idx on the way out keeps the address at 0 while idle.
            CONCLUIDO: begin
                criacao_concluida_tiro = 1'b1;
                idx_prox               = '0;
                prox_estado            = ESPERA;
            end
            SEM_ESPACO: begin
                criacao_concluida_tiro = 1'b1;
                tabela_cheia           = 1'b1;
                idx_prox               = '0;
                prox_estado            = ESPERA;
            end
            default: prox_estado = INICIAL;
        endcase
    end

endmodule
